load_queue: RTL and testbench
=============================

// Module: load_queue
// PURPOSE
//  In-order load queue; sits directly upstream of the data cache (ds) on the `load` interface.
//  Accepts dispatched loads, issues one block query at a time, and tracks hit / miss-ack / fill-answer.
//  Retires completed loads in program order as 32-bit words to writeback.
// PARAMETERS
//  SIZE    8   entries, power of two >= 2; index width IDX_W = $clog2(SIZE)
//  ADDR_W  16  byte-address width; block index = addr[ADDR_W-1:3]
// PORTS
//  clock        in   1         rising-edge clock
//  reset        in   1         synchronous, active-high
//  alloc_valid  in   1         dispatch presents a load
//  alloc_addr   in   ADDR_W    byte address, 4-byte aligned
//  alloc_ready  out  1         entry free; allocate on valid&ready
//  alloc_idx    out  IDX_W     LQ index assigned (tail)
//  load         if   -         load.lq modport; drives qry / qry_mem_idx / qry_lq_idx;
//                              reads hit/hit_blk, ack/ack_head, ans/ans_head/ans_blk
//  out_valid    out  1         head entry DONE
//  out_data     out  32        selected word of head block
//  out_idx      out  IDX_W     head LQ index
//  out_ready    in   1         writeback accepts; pop on valid&ready
// BEHAVIOUR
//  - Entry state LQ_STATE_T: EMPTY -> READY (alloc) -> WAIT_ACK (selected for query)
//    -> DONE (hit) | WAIT_ANS (ack) -> DONE (ans) -> EMPTY (pop).
//  - Pointers head/tail are IDX_W+1 bits; full = MSBs differ & low bits equal; empty = equal.
//  - alloc_ready = !full; no same-cycle bypass: full+pop does not admit an alloc that cycle.
//  - Query: at most one entry in WAIT_ACK. When none, the oldest READY entry (scan from head,
//    wrapping) moves to WAIT_ACK the next edge. qry = 1 while an entry is in WAIT_ACK;
//    qry_mem_idx / qry_lq_idx are held stable until resolved.
//  - Resolution is sampled at the posedge with qry=1. hit: entry -> DONE, block := hit_blk.
//    ack: entry ack_head -> WAIT_ANS. Neither: keep querying. hit & ack together: hit wins.
//  - Next query issues the cycle after resolution (min one idle cycle between queries).
//  - ans: entry ans_head in WAIT_ANS -> DONE, block := ans_blk. ans to a non-WAIT_ANS
//    entry is ignored (assertion fires in simulation).
//  - Simultaneous events (alloc, resolve, ans, pop) on distinct entries all take effect
//    in the same cycle.
//  - out_data = addr[2] ? block[63:32] : block[31:0]. Pop frees the head, head++ (wraps).
//  - Latency: alloc on an empty queue with a hit -> qry raised edge+1, resolved edge+2,
//    out_valid at edge+2.
//  - Reset (any time, including mid-miss): every entry EMPTY, head = tail = 0; after the edge
//    qry=0, qry_mem_idx=0, qry_lq_idx=0, out_valid=0, out_data=0, out_idx=0,
//    alloc_ready=1, alloc_idx=0. A late ans after reset is ignored.
// CONFIGURATION
//  LQ_COALESCE_EN defined: on ans, every WAIT_ANS/READY entry with an equal block index also
//    takes ans_blk -> DONE. A READY entry whose block matches the in-flight WAIT_ACK/WAIT_ANS
//    entry is not selected for query.
//  Undefined: each entry queries and completes independently; duplicate misses go to the cache.
// STRUCTURE
//  - Shared package / defs.svh: LQ_STATE_T {LQ_EMPTY, LQ_READY, LQ_WAIT_ACK, LQ_WAIT_ANS,
//    LQ_DONE}, LQ_ENTRY_T {state, addr, blk}, and the load interface with its lq modport.
//  - Sub-module lq_picker: combinational oldest-READY selector rotated by head;
//    outputs valid + index.
// TESTING
//  1 reset, idle 2 cycles -> qry=0, out_valid=0, alloc_ready=1, all outputs 0.
//  2 alloc 0x0010; hit=1, hit_blk=64'hdeadbeefcc00ffee at the first qry edge
//    -> qry_mem_idx=2, qry_lq_idx=0; out_valid with out_data=32'hcc00ffee.
//  3 alloc 0x0014; miss for 2 cycles (qry held, idx 2); ack=1, ack_head=0;
//    later ans, ans_head=0, ans_blk=64'h1122334455667788 -> out_data=32'h11223344.
//  4 fill all 8 with out_ready=0 -> alloc_ready=0 after 8th; pop one -> alloc_ready=1,
//    alloc_idx wraps to 0.
//  5 two loads to 0x0010 and 0x0014, miss -> with LQ_COALESCE_EN one qry and both DONE on ans;
//    without, two qry sequences.
//  6 reset asserted while in WAIT_ANS, then ans arrives -> ignored, queue empty, out_valid=0.

Source files
------------

// File: rtl/load_queue_pkg.sv
// Shared types for the in-order load queue: entry state, entry record, word select.
package load_queue_pkg;

  localparam int LQ_ADDR_W = 16;
  localparam int LQ_BLK_W  = 64;

  typedef enum logic [2:0] {
    LQ_EMPTY,
    LQ_READY,
    LQ_WAIT_ACK,
    LQ_WAIT_ANS,
    LQ_DONE
  } LQ_STATE_T;

  typedef struct packed {
    LQ_STATE_T              state;
    logic [LQ_ADDR_W-1:0]   addr;
    logic [LQ_BLK_W-1:0]    blk;
  } LQ_ENTRY_T;

  // Pick the 32-bit word of a 64-bit block addressed by byte-address bit 2.
  function automatic logic [31:0] lq_word(input logic [LQ_BLK_W-1:0] blk, input logic hi);
    return hi ? blk[63:32] : blk[31:0];
  endfunction

endpackage

// File: rtl/load_queue_if.sv
// Load interface between the load queue (lq) and the data cache (ds).
interface load_if #(
  parameter int SIZE   = 8,
  parameter int ADDR_W = 16
);
  localparam int IDX_W = $clog2(SIZE);

  logic              qry;
  logic [ADDR_W-4:0] qry_mem_idx;
  logic [IDX_W-1:0]  qry_lq_idx;
  logic              hit;
  logic [63:0]       hit_blk;
  logic              ack;
  logic [IDX_W-1:0]  ack_head;
  logic              ans;
  logic [IDX_W-1:0]  ans_head;
  logic [63:0]       ans_blk;

  modport lq (
    output qry, qry_mem_idx, qry_lq_idx,
    input  hit, hit_blk, ack, ack_head, ans, ans_head, ans_blk
  );

  modport ds (
    input  qry, qry_mem_idx, qry_lq_idx,
    output hit, hit_blk, ack, ack_head, ans, ans_head, ans_blk
  );
endinterface

// File: rtl/load_queue_picker.sv
// lq_picker: combinational oldest-first selector; scans the request vector starting at head.
module lq_picker #(
  parameter int SIZE = 8,
  localparam int IDX_W = $clog2(SIZE)
) (
  input  logic [SIZE-1:0]  req_i,
  input  logic [IDX_W-1:0] head_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [IDX_W-1:0] cand;

  // Walk from youngest offset down so the entry nearest head is written last and wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      cand = head_i + IDX_W'(i);
      if (req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/load_queue.sv
// load_queue: in-order load queue in front of the data cache. One block query in flight at a
// time; tracks hit / ack / fill answer per entry and retires 32-bit words in program order.
// Optional build macro LQ_COALESCE_EN: a fill answer also completes every queued load to the
// same block, and such loads are never queried while a matching query/miss is outstanding.
module load_queue
  import load_queue_pkg::*;
#(
  parameter int SIZE   = 8,
  parameter int ADDR_W = 16,
  localparam int IDX_W = $clog2(SIZE)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alloc_valid,
  input  logic [ADDR_W-1:0] alloc_addr,
  output logic              alloc_ready,
  output logic [IDX_W-1:0]  alloc_idx,
  load_if.lq                load,
  output logic              out_valid,
  output logic [31:0]       out_data,
  output logic [IDX_W-1:0]  out_idx,
  input  logic              out_ready
);

  LQ_ENTRY_T        ent_q [SIZE];
  LQ_ENTRY_T        ent_d [SIZE];
  logic [IDX_W:0]   head_q, head_d, tail_q, tail_d;
  logic             qry_q, qry_d;
  logic [IDX_W-1:0] qry_idx_q, qry_idx_d;

  logic [IDX_W-1:0] head_idx, tail_idx;
  logic             full, push, pop, ans_ok;
  logic [SIZE-1:0]  pick_req;
  logic             pick_vld;
  logic [IDX_W-1:0] pick_idx;

  assign head_idx    = head_q[IDX_W-1:0];
  assign tail_idx    = tail_q[IDX_W-1:0];
  assign full        = (head_q[IDX_W] != tail_q[IDX_W]) && (head_idx == tail_idx);
  assign alloc_ready = !full;
  assign alloc_idx   = tail_idx;
  assign push        = alloc_valid && !full;

  assign out_valid   = (ent_q[head_idx].state == LQ_DONE);
  assign out_idx     = head_idx;
  assign out_data    = out_valid ? lq_word(ent_q[head_idx].blk, ent_q[head_idx].addr[2]) : 32'h0;
  assign pop         = out_valid && out_ready;

  assign load.qry         = qry_q;
  assign load.qry_lq_idx  = qry_idx_q;
  assign load.qry_mem_idx = qry_q ? ent_q[qry_idx_q].addr[ADDR_W-1:3] : '0;

  assign ans_ok = load.ans && (ent_q[load.ans_head].state == LQ_WAIT_ANS);

  // Query candidates: READY entries (minus ones already covered by an outstanding block miss).
  always_comb begin
    pick_req = '0;
    for (int i = 0; i < SIZE; i++) begin
      pick_req[i] = (ent_q[i].state == LQ_READY);
`ifdef LQ_COALESCE_EN
      for (int j = 0; j < SIZE; j++) begin
        if ((ent_q[j].state == LQ_WAIT_ACK || ent_q[j].state == LQ_WAIT_ANS) &&
            ent_q[j].addr[ADDR_W-1:3] == ent_q[i].addr[ADDR_W-1:3])
          pick_req[i] = 1'b0;
      end
`endif
    end
  end

  lq_picker #(.SIZE(SIZE)) u_picker (
    .req_i   (pick_req),
    .head_i  (head_idx),
    .valid_o (pick_vld),
    .idx_o   (pick_idx)
  );

  // Next-state: resolve/issue query, fill answer, pop and alloc all apply in one cycle.
  always_comb begin
    ent_d     = ent_q;
    head_d    = head_q;
    tail_d    = tail_q;
    qry_d     = qry_q;
    qry_idx_d = qry_idx_q;
    if (qry_q) begin
      if (load.hit) begin
        ent_d[qry_idx_q].state = LQ_DONE;
        ent_d[qry_idx_q].blk   = load.hit_blk;
        qry_d                  = 1'b0;
      end else if (load.ack) begin
        if (ent_q[load.ack_head].state == LQ_WAIT_ACK)
          ent_d[load.ack_head].state = LQ_WAIT_ANS;
        qry_d = 1'b0;
      end
    end else if (pick_vld) begin
      ent_d[pick_idx].state = LQ_WAIT_ACK;
      qry_d                 = 1'b1;
      qry_idx_d             = pick_idx;
    end
    if (ans_ok) begin
      ent_d[load.ans_head].state = LQ_DONE;
      ent_d[load.ans_head].blk   = load.ans_blk;
`ifdef LQ_COALESCE_EN
      for (int i = 0; i < SIZE; i++) begin
        if ((ent_q[i].state == LQ_WAIT_ANS || ent_q[i].state == LQ_READY) &&
            ent_q[i].addr[ADDR_W-1:3] == ent_q[load.ans_head].addr[ADDR_W-1:3]) begin
          ent_d[i].state = LQ_DONE;
          ent_d[i].blk   = load.ans_blk;
        end
      end
`endif
    end
    if (pop) begin
      ent_d[head_idx].state = LQ_EMPTY;
      head_d                = head_q + (IDX_W+1)'(1);
    end
    if (push) begin
      ent_d[tail_idx].state = LQ_READY;
      ent_d[tail_idx].addr  = LQ_ADDR_W'(alloc_addr);
      tail_d                = tail_q + (IDX_W+1)'(1);
    end
  end

  // State register; reset clears control only, addresses and blocks are don't-care when EMPTY.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < SIZE; i++) ent_q[i].state <= LQ_EMPTY;
      head_q    <= '0;
      tail_q    <= '0;
      qry_q     <= 1'b0;
      qry_idx_q <= '0;
    end else begin
      ent_q     <= ent_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      qry_q     <= qry_d;
      qry_idx_q <= qry_idx_d;
    end
  end

  a_ans_to_wait_ans: assert property (@(posedge clock) disable iff (reset)
    load.ans |-> (ent_q[load.ans_head].state == LQ_WAIT_ANS));

endmodule

// File: tb/tb_load_queue.sv
// Directed bench for load_queue with a scoreboard: expected retirements and expected queries
// are queued by the stimulus and popped by independent monitors.
module tb_load_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic        alloc_valid;
  logic [15:0] alloc_addr;
  logic        alloc_ready;
  logic [2:0]  alloc_idx;
  logic        out_valid;
  logic [31:0] out_data;
  logic [2:0]  out_idx;
  logic        out_ready;

  load_if #(.SIZE(8), .ADDR_W(16)) lif ();

  load_queue #(.SIZE(8), .ADDR_W(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .alloc_valid (alloc_valid),
    .alloc_addr  (alloc_addr),
    .alloc_ready (alloc_ready),
    .alloc_idx   (alloc_idx),
    .load        (lif),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_idx     (out_idx),
    .out_ready   (out_ready)
  );

  always #5 clock = ~clock;

  typedef struct { logic [2:0] idx; logic [31:0] data; } out_t;
  typedef struct { logic [12:0] mem; logic [2:0] lq; } qry_t;
  out_t exp_out[$];
  qry_t exp_qry[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_qry"}, 64'(lif.qry), 64'd0);
    chk({tag, "_qry_mem_idx"}, 64'(lif.qry_mem_idx), 64'd0);
    chk({tag, "_qry_lq_idx"}, 64'(lif.qry_lq_idx), 64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_data"}, 64'(out_data), 64'd0);
    chk({tag, "_out_idx"}, 64'(out_idx), 64'd0);
    chk({tag, "_alloc_ready"}, 64'(alloc_ready), 64'd1);
    chk({tag, "_alloc_idx"}, 64'(alloc_idx), 64'd0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    lif.hit = 1'b0; lif.ack = 1'b0; lif.ans = 1'b0;
    alloc_valid = 1'b0;
    tick(2);
    check_idle(tag);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic do_alloc(input logic [15:0] addr, input logic [2:0] idx);
    alloc_valid = 1'b1;
    alloc_addr  = addr;
    chk("alloc_ready", 64'(alloc_ready), 64'd1);
    chk("alloc_idx", 64'(alloc_idx), 64'(idx));
    tick(1);
    alloc_valid = 1'b0;
  endtask

  task automatic wait_qry();
    for (int k = 0; k < 20 && !lif.qry; k++) tick(1);
    chk("qry_raised", 64'(lif.qry), 64'd1);
  endtask

  // Retirement monitor and query monitor.
  out_t e_out;
  qry_t e_qry;
  logic qry_prev = 1'b0;
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (out_valid && out_ready) begin
          if (exp_out.size() == 0) begin
            checks++; errors++;
            $display("FAIL out_unexpected actual idx=%0d data=%0h required none", out_idx, out_data);
          end else begin
            e_out = exp_out.pop_front();
            chk("out_idx", 64'(out_idx), 64'(e_out.idx));
            chk("out_data", 64'(out_data), 64'(e_out.data));
          end
        end
        if (lif.qry && !qry_prev) begin
          if (exp_qry.size() == 0) begin
            checks++; errors++;
            $display("FAIL qry_unexpected actual mem=%0h lq=%0d required none",
                     lif.qry_mem_idx, lif.qry_lq_idx);
          end else begin
            e_qry = exp_qry.pop_front();
            chk("qry_mem_idx", 64'(lif.qry_mem_idx), 64'(e_qry.mem));
            chk("qry_lq_idx", 64'(lif.qry_lq_idx), 64'(e_qry.lq));
          end
        end
      end
      qry_prev = lif.qry;
    end
  end

  initial begin
    reset = 1'b1; alloc_valid = 1'b0; alloc_addr = '0; out_ready = 1'b0;
    lif.hit = 1'b0; lif.hit_blk = '0; lif.ack = 1'b0; lif.ack_head = '0;
    lif.ans = 1'b0; lif.ans_head = '0; lif.ans_blk = '0;

    // 1: reset then idle
    tick(1);
    do_reset("rst");
    tick(2);
    check_idle("idle");

    // 2: hit path and latency
    out_ready = 1'b1;
    exp_qry.push_back('{13'd2, 3'd0});
    do_alloc(16'h0010, 3'd0);
    chk("t2_qry_edge1", 64'(lif.qry), 64'd0);
    tick(1);
    chk("t2_qry_edge2", 64'(lif.qry), 64'd1);
    chk("t2_mem_idx", 64'(lif.qry_mem_idx), 64'd2);
    lif.hit = 1'b1; lif.hit_blk = 64'hdeadbeefcc00ffee;
    exp_out.push_back('{3'd0, 32'hcc00ffee});
    tick(1);
    lif.hit = 1'b0;
    chk("t2_out_valid", 64'(out_valid), 64'd1);
    chk("t2_out_data", 64'(out_data), 64'hcc00ffee);
    tick(2);

    // 3: miss, ack, later fill
    do_reset("t3rst");
    exp_qry.push_back('{13'd2, 3'd0});
    do_alloc(16'h0014, 3'd0);
    wait_qry();
    tick(2);
    chk("t3_qry_held", 64'(lif.qry), 64'd1);
    chk("t3_mem_held", 64'(lif.qry_mem_idx), 64'd2);
    lif.ack = 1'b1; lif.ack_head = 3'd0;
    tick(1);
    lif.ack = 1'b0;
    chk("t3_qry_after_ack", 64'(lif.qry), 64'd0);
    chk("t3_out_valid_wait", 64'(out_valid), 64'd0);
    tick(2);
    lif.ans = 1'b1; lif.ans_head = 3'd0; lif.ans_blk = 64'h1122334455667788;
    exp_out.push_back('{3'd0, 32'h11223344});
    tick(1);
    lif.ans = 1'b0;
    chk("t3_out_data", 64'(out_data), 64'h11223344);
    tick(2);

    // 4: fill, full, no bypass on full+pop, wrap
    do_reset("t4rst");
    out_ready = 1'b0;
    exp_qry.push_back('{13'h20, 3'd0});
    for (int i = 0; i < 8; i++) do_alloc(16'h0100 + 16'(4 * i), 3'(i));
    chk("t4_full", 64'(alloc_ready), 64'd0);
    alloc_valid = 1'b1; alloc_addr = 16'h0300;
    tick(1);
    alloc_valid = 1'b0;
    chk("t4_full_reject_idx", 64'(alloc_idx), 64'd0);
    chk("t4_full_hold", 64'(alloc_ready), 64'd0);
    lif.hit = 1'b1; lif.hit_blk = 64'h5555666677778888;
    exp_out.push_back('{3'd0, 32'h77778888});
    exp_qry.push_back('{13'h20, 3'd1});
    tick(1);
    lif.hit = 1'b0;
    chk("t4_head_done", 64'(out_valid), 64'd1);
    chk("t4_still_full", 64'(alloc_ready), 64'd0);
    out_ready = 1'b1; alloc_valid = 1'b1; alloc_addr = 16'h0200;
    tick(1);
    alloc_valid = 1'b0;
    chk("t4_ready_after_pop", 64'(alloc_ready), 64'd1);
    chk("t4_idx_wrap", 64'(alloc_idx), 64'd0);
    tick(3);

    // 5: two loads to the same block
    do_reset("t5rst");
    out_ready = 1'b1;
    exp_qry.push_back('{13'd2, 3'd0});
    do_alloc(16'h0010, 3'd0);
    do_alloc(16'h0014, 3'd1);
    wait_qry();
    lif.ack = 1'b1; lif.ack_head = 3'd0;
    tick(1);
    lif.ack = 1'b0;
`ifdef LQ_COALESCE_EN
    tick(3);
    chk("t5_no_second_qry", 64'(lif.qry), 64'd0);
`else
    exp_qry.push_back('{13'd2, 3'd1});
    wait_qry();
    lif.ack = 1'b1; lif.ack_head = 3'd1;
    tick(1);
    lif.ack = 1'b0;
`endif
    lif.ans = 1'b1; lif.ans_head = 3'd0; lif.ans_blk = 64'ha1a2a3a4b1b2b3b4;
    exp_out.push_back('{3'd0, 32'hb1b2b3b4});
    exp_out.push_back('{3'd1, 32'ha1a2a3a4});
    tick(1);
    lif.ans = 1'b0;
`ifndef LQ_COALESCE_EN
    tick(1);
    lif.ans = 1'b1; lif.ans_head = 3'd1;
    tick(1);
    lif.ans = 1'b0;
`endif
    tick(4);

    // 6: reset while waiting for a fill, then the fill shows up
    do_reset("t6rst");
    exp_qry.push_back('{13'd3, 3'd0});
    do_alloc(16'h0018, 3'd0);
    wait_qry();
    lif.ack = 1'b1; lif.ack_head = 3'd0;
    tick(1);
    lif.ack = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(1);
    lif.ans = 1'b1; lif.ans_head = 3'd0; lif.ans_blk = 64'h0badf00d0badf00d;
    tick(1);
    lif.ans = 1'b0;
    tick(1);
    check_idle("t6_in_reset");
    reset = 1'b0;
    tick(3);
    check_idle("t6_after");

    for (int k = 0; k < 20 && (exp_out.size() != 0 || exp_qry.size() != 0); k++) tick(1);
    chk("exp_out_drained", 64'(exp_out.size()), 64'd0);
    chk("exp_qry_drained", 64'(exp_qry.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
